// File: rtl/multi_serializer.sv
// ============================================================================
// multi_serializer
// ----------------------------------------------------------------------------
// Multi-lane parallel-to-serial converter. CH_N words of DATA_W bits are
// shifted out in lock-step, one bit per lane per clock. Upstream word sets
// arrive through a valid/ready handshake into a one-entry holding buffer.
// When no word set is available at a word boundary, IDLE_WORD is loaded on
// every lane and underrun_o pulses.
//
// Optional feature macro: SER_UNDERRUN_CNT_EN
//   When defined, adds underrun_cnt_o, a 16-bit saturating count of underrun
//   events, cleared only by rst_i.
//
// Parameters:
//   DATA_W     bits per word per lane (2..32)
//   CH_N       number of lanes
//   MSB_FIRST  0: bit 0 is sent first; 1: bit DATA_W-1 is sent first
//   IDLE_WORD  word loaded on every lane on underrun
//
// Ports:
//   clk_i           in   bit clock (serial rate)
//   rst_i           in   synchronous active-high reset
//   data_i          in   CH_N*DATA_W parallel words, lane k at [k*DATA_W +: DATA_W]
//   valid_i         in   data_i holds a word set for all lanes
//   ready_o         out  block accepts data_i this cycle
//   data_o          out  CH_N serial bits, one per lane
//   word_start_o    out  high while data_o carries the first bit of a word
//   underrun_o      out  one-cycle pulse: IDLE_WORD was loaded
//   underrun_cnt_o  out  saturating underrun count (SER_UNDERRUN_CNT_EN only)
// ============================================================================
module multi_serializer #(
    parameter int                DATA_W    = 10,
    parameter int                CH_N      = 3,
    parameter int                MSB_FIRST = 0,
    parameter logic [DATA_W-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CH_N*DATA_W-1:0]   data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [CH_N-1:0]          data_o,
    output logic                     word_start_o,
    output logic                     underrun_o
`ifdef SER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]              underrun_cnt_o
`endif
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
            $error("multi_serializer: DATA_W=%0d outside legal range 2..32", DATA_W);
        end
        if (CH_N < 1) begin : g_bad_ch_n
            $error("multi_serializer: CH_N=%0d must be at least 1", CH_N);
        end
    endgenerate

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam int                SET_W    = CH_N * DATA_W;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [SET_W-1:0] hold_reg;
    logic [SET_W-1:0] hold_next;
    logic             hold_valid_reg;
    logic             hold_valid_next;
    logic             word_start_reg;
    logic             underrun_reg;
    logic             underrun_next;

    // Word set presented to all shift registers on a load edge.
    logic [SET_W-1:0] load_word;
    logic             load;
    logic             accept;

    // ------------------------------------------------------------------------
    // Control: bit counter, holding buffer and load-source selection
    // ------------------------------------------------------------------------
    always_comb begin
        load            = (cnt_reg == CNT_LAST);
        // At a word boundary the buffer drains into the shift registers on
        // the same edge, so it can take a new word even while full.
        ready_o         = !hold_valid_reg || load;
        accept          = valid_i && ready_o;

        cnt_next        = cnt_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        underrun_next   = 1'b0;
        load_word       = hold_reg;

        if (load) begin
            cnt_next = '0;
            if (hold_valid_reg) begin
                load_word = hold_reg;
                if (accept) begin
                    hold_next       = data_i;
                    hold_valid_next = 1'b1;
                end else begin
                    hold_valid_next = 1'b0;
                end
            end else if (accept) begin
                // Bypass: an empty buffer lets a word arriving exactly on
                // the boundary go straight to the shift registers.
                load_word       = data_i;
                hold_valid_next = 1'b0;
            end else begin
                load_word     = {CH_N{IDLE_WORD}};
                underrun_next = 1'b1;
            end
        end else begin
            cnt_next = cnt_reg + 1'b1;
            if (accept) begin
                hold_next       = data_i;
                hold_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg        <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            word_start_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            // The first bit of a newly loaded word is visible in the cycle
            // after the load edge, which is exactly when these flags are up.
            word_start_reg <= load;
            underrun_reg   <= underrun_next;
        end
    end

    assign word_start_o = word_start_reg;
    assign underrun_o   = underrun_reg;

    // ------------------------------------------------------------------------
    // Per-lane shift registers. All lanes share the same load/shift control,
    // so they stay bit-aligned with no skew between lanes.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CH_N; gi++) begin : g_lane
            logic [DATA_W-1:0] shift_reg;
            logic [DATA_W-1:0] shift_next;

            // Shift toward the output end, filling with zero.
            if (MSB_FIRST != 0) begin : g_msb
                assign shift_next = {shift_reg[DATA_W-2:0], 1'b0};
                assign data_o[gi] = shift_reg[DATA_W-1];
            end else begin : g_lsb
                assign shift_next = {1'b0, shift_reg[DATA_W-1:1]};
                assign data_o[gi] = shift_reg[0];
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    shift_reg <= '0;
                end else if (load) begin
                    shift_reg <= load_word[gi*DATA_W +: DATA_W];
                end else begin
                    shift_reg <= shift_next;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Optional saturating underrun counter
    // ------------------------------------------------------------------------
`ifdef SER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underrun_cnt_reg <= '0;
        end else if (underrun_next && (underrun_cnt_reg != 16'hFFFF)) begin
            underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
        end
    end

    assign underrun_cnt_o = underrun_cnt_reg;
`endif

endmodule

// File: tb/tb_multi_serializer.sv
// ============================================================================
// tb_multi_serializer
// ----------------------------------------------------------------------------
// Bench for multi_serializer. A default instance (DATA_W=10, CH_N=3,
// LSB first) is checked cycle by cycle against a transaction-level model
// built from a word queue and the edge count since reset. A second instance
// (DATA_W=8, CH_N=2, MSB first) is checked with directed expectations,
// including a reset in the middle of a word.
// ============================================================================
module tb_multi_serializer;

    localparam logic [9:0] IDLE  = 10'b1101010100;
    localparam logic [7:0] MIDLE = 8'hB5;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [29:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  data_o;
    logic        word_start_o;
    logic        underrun_o;
    logic [15:0] ucnt;

    logic        m_rst = 1'b1;
    logic [15:0] m_data = '0;
    logic        m_valid = 1'b0;
    logic        m_ready;
    logic [1:0]  m_data_o;
    logic        m_ws;
    logic        m_ur;
    logic [15:0] m_cnt;

    always #5 clk_i = ~clk_i;

    multi_serializer #(
        .DATA_W(10), .CH_N(3), .MSB_FIRST(0), .IDLE_WORD(IDLE)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .word_start_o (word_start_o),
        .underrun_o   (underrun_o)
`ifdef SER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o(ucnt)
`endif
    );

    multi_serializer #(
        .DATA_W(8), .CH_N(2), .MSB_FIRST(1), .IDLE_WORD(MIDLE)
    ) u_msb (
        .clk_i        (clk_i),
        .rst_i        (m_rst),
        .data_i       (m_data),
        .valid_i      (m_valid),
        .ready_o      (m_ready),
        .data_o       (m_data_o),
        .word_start_o (m_ws),
        .underrun_o   (m_ur)
`ifdef SER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o(m_cnt)
`endif
    );

`ifndef SER_UNDERRUN_CNT_EN
    assign ucnt  = '0;
    assign m_cnt = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          e;            // edges since reset deassertion
    logic [29:0] pend_q[$];    // words accepted but not yet on the wire
    logic [29:0] cur_word;     // word currently being sent
    int          bit_idx;      // sending position within cur_word
    bit          exp_ws;
    bit          exp_ur;
    int          ur_cnt;
    int          ur_seen;      // underrun pulses seen on the DUT in a phase

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e        = 0;
        pend_q.delete();
        cur_word = '0;
        bit_idx  = 0;
        exp_ws   = 0;
        exp_ur   = 0;
        ur_cnt   = 0;
    endtask

    // Entered and left on a negedge.
    task automatic do_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_data_o", data_o, 0);
        check("rst_word_start", word_start_o, 0);
        check("rst_underrun", underrun_o, 0);
        check("rst_ready", ready_o, 1);
`ifdef SER_UNDERRUN_CNT_EN
        check("rst_ucnt", ucnt, 0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    // One clock of the default instance. Entered and left on a negedge.
    task automatic cycle(input bit v, input logic [29:0] d, output bit acc);
        bit         boundary;
        bit         exp_ready;
        logic [2:0] exp_d;
        valid_i   = v;
        data_i    = d;
        boundary  = ((e % 10) == 9);
        exp_ready = (pend_q.size() == 0) || boundary;
        #1;
        check("ready", ready_o, exp_ready);
        acc = v && exp_ready;
        @(posedge clk_i);
        exp_ws = 0;
        exp_ur = 0;
        if (boundary) begin
            if (pend_q.size() != 0) begin
                cur_word = pend_q.pop_front();
                if (acc) pend_q.push_back(d);
            end else if (acc) begin
                cur_word = d;
            end else begin
                cur_word = {3{IDLE}};
                exp_ur   = 1;
                if (ur_cnt < 65535) ur_cnt++;
            end
            bit_idx = 0;
            exp_ws  = 1;
        end else begin
            bit_idx++;
            if (acc) pend_q.push_back(d);
        end
        e++;
        #1;
        for (int k = 0; k < 3; k++) exp_d[k] = cur_word[k*10 + bit_idx];
        check("data_o", data_o, exp_d);
        check("word_start", word_start_o, exp_ws);
        check("underrun", underrun_o, exp_ur);
`ifdef SER_UNDERRUN_CNT_EN
        check("ucnt", ucnt, ur_cnt);
`endif
        if (underrun_o === 1'b1) ur_seen++;
        @(negedge clk_i);
    endtask

    initial begin
        bit          acc;
        bit          v;
        logic [29:0] d;
        int          w;
        int          prob;
        logic [1:0]  m_exp;
        logic [7:0]  m80;
        logic [7:0]  midle_v;

        model_reset();
        @(negedge clk_i);
        do_reset();

        // Constant word set held valid: 2AA / 155 / 3FF
        ur_seen = 0;
        for (int i = 0; i < 40; i++) cycle(1'b1, {10'h3FF, 10'h155, 10'h2AA}, acc);
        check("const_no_underrun", ur_seen, 0);

        // No upstream data: idle words and one underrun per word
        do_reset();
        ur_seen = 0;
        for (int i = 0; i < 30; i++) cycle(1'b0, 30'h0, acc);
        check("idle_underruns", ur_seen, 3);

        // Bypass: single word offered only on the first load edge
        do_reset();
        for (int i = 0; i < 25; i++) begin
            cycle((i == 9), {10'h001, 10'h001, 10'h001}, acc);
            if (i == 9) check("bypass_accept", acc, 1);
        end

        // Back-pressure with incrementing words
        do_reset();
        w = 0;
        ur_seen = 0;
        for (int i = 0; i < 60; i++) begin
            d = {10'(w + 2), 10'(w + 1), 10'(w)};
            cycle(1'b1, d, acc);
            if (acc) w++;
        end
        check("bp_accepted", w, 7);
        check("bp_no_underrun", ur_seen, 0);

        // Random traffic with a reset in the middle of a word
        do_reset();
        v = 0;
        d = '0;
        for (int i = 0; i < 300; i++) begin
            if (i == 153) begin
                do_reset();
                v = 0;
            end
            prob = (i < 100) ? 90 : ((i < 200) ? 40 : 15);
            if (!v && ($urandom_range(0, 99) < prob)) begin
                v = 1;
                d = 30'($urandom);
            end
            cycle(v, d, acc);
            if (acc) v = 0;
        end
        valid_i = 1'b0;

        // MSB-first instance: word 8'h80 then idle, reset at bit 3
        m80     = 8'h80;
        midle_v = MIDLE;
        m_rst   = 1'b0;
        m_valid = 1'b1;
        m_data  = {m80, m80};
        for (int i = 0; i <= 18; i++) begin
            @(posedge clk_i);
            #1;
            if (i == 0) m_valid = 1'b0;
            if (i >= 7 && i <= 14)
                m_exp = {2{m80[7 - (i - 7)]}};
            else if (i >= 15)
                m_exp = {2{midle_v[7 - (i - 15)]}};
            else
                m_exp = 2'b00;
            check("msb_data_o", m_data_o, m_exp);
            check("msb_word_start", m_ws, (i == 7 || i == 15));
            check("msb_underrun", m_ur, (i == 15));
        end
        @(negedge clk_i);
        m_rst = 1'b1;
        @(posedge clk_i);
        #1;
        check("msb_rst_data_o", m_data_o, 0);
        check("msb_rst_word_start", m_ws, 0);
        check("msb_rst_ready", m_ready, 1);
        @(negedge clk_i);
        m_rst = 1'b0;
        for (int j = 0; j <= 7; j++) begin
            @(posedge clk_i);
            #1;
            check("msb_restart_ws", m_ws, (j == 7));
            check("msb_restart_ur", m_ur, (j == 7));
            check("msb_restart_data", m_data_o, (j == 7) ? 2'b11 : 2'b00);
        end
`ifdef SER_UNDERRUN_CNT_EN
        check("msb_ucnt", m_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
